// File: rtl/load_access_ctrl.sv
// load_access_ctrl: runs one load at a time from the memory stage to the data memory and merges the result.
// Latency: accept N, mem_read N+1, wb_valid N+2 with zero wait states; rejected requests reach writeback at N+1.
// Backpressure: req_ready is low from accept until the writeback handshake; READ holds on mem_waitrequest, WB holds on wb_ready.
// Optional: define LOAD_ACCESS_CTRL_TIMEOUT_EN to abandon a read after TIMEOUT_CYCLES wait states.
module load_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_rt_old,
  input  logic [4:0]  req_dest,
  output logic        mem_read,
  output logic [31:0] mem_address,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dest,
  output logic        wb_err
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  logic [1:0]  state;
  logic [5:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] rt_q;
  logic [4:0]  dest_q;
  logic [31:0] data_q;
  logic        err_q;

  logic        req_bad;
  logic        timeout;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] merged;

  // Reject unknown opcodes and misaligned LW/LH/LHU before any memory access
  always_comb begin
    req_bad = 1'b0;
    case (req_opcode)
      OP_LB, OP_LBU, OP_LWL, OP_LWR: req_bad = 1'b0;
      OP_LH, OP_LHU:                 req_bad = req_addr[0];
      OP_LW:                         req_bad = |req_addr[1:0];
      default:                       req_bad = 1'b1;
    endcase
  end

  // Big-endian lane selection and merge of the returned word with the old rt value
  always_comb begin
    byte_sel = mem_readdata[31:24];
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_readdata[31:24];
      2'd1:    byte_sel = mem_readdata[23:16];
      2'd2:    byte_sel = mem_readdata[15:8];
      default: byte_sel = mem_readdata[7:0];
    endcase
    half_sel = addr_q[1] ? mem_readdata[15:0] : mem_readdata[31:16];
    merged   = mem_readdata;
    case (op_q)
      OP_LB:  merged = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: merged = {24'h0, byte_sel};
      OP_LH:  merged = {{16{half_sel[15]}}, half_sel};
      OP_LHU: merged = {16'h0, half_sel};
      OP_LWL: begin
        case (addr_q[1:0])
          2'd0:    merged = mem_readdata;
          2'd1:    merged = {mem_readdata[23:0], rt_q[7:0]};
          2'd2:    merged = {mem_readdata[15:0], rt_q[15:0]};
          default: merged = {mem_readdata[7:0], rt_q[23:0]};
        endcase
      end
      OP_LWR: begin
        case (addr_q[1:0])
          2'd0:    merged = {rt_q[31:8], mem_readdata[31:24]};
          2'd1:    merged = {rt_q[31:16], mem_readdata[31:16]};
          2'd2:    merged = {rt_q[31:24], mem_readdata[31:8]};
          default: merged = mem_readdata;
        endcase
      end
      default: merged = mem_readdata;
    endcase
  end

`ifdef LOAD_ACCESS_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  // The timeout fires on the wait cycle that brings the count to TIMEOUT_CYCLES; a response always wins
  assign timeout = mem_waitrequest && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count wait-state cycles of the current read; idle outside READ so each read starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state != ST_READ) begin
      wait_cnt <= '0;
    end else if (mem_waitrequest) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;

  assign timeout    = 1'b0;
  assign unused_cnt = CNT_W'(TIMEOUT_CYCLES);
`endif

  // Sequencer: capture request, hold the read through wait states, hold the result until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      addr_q <= '0;
      rt_q   <= '0;
      dest_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q   <= req_opcode;
            addr_q <= req_addr;
            rt_q   <= req_rt_old;
            dest_q <= req_dest;
            if (req_bad) begin
              data_q <= '0;
              err_q  <= 1'b1;
              state  <= ST_WB;
            end else begin
              state  <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (!mem_waitrequest) begin
            data_q <= merged;
            err_q  <= 1'b0;
            state  <= ST_WB;
          end else if (timeout) begin
            data_q <= '0;
            err_q  <= 1'b1;
            state  <= ST_WB;
          end
        end
        ST_WB: begin
          if (wb_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // req_ready is forced low during reset even though the state register already reads IDLE
  assign req_ready   = rst_n && (state == ST_IDLE);
  assign mem_read    = (state == ST_READ);
  assign mem_address = {addr_q[31:2], 2'b00};
  assign wb_valid    = (state == ST_WB);
  assign wb_data     = data_q;
  assign wb_dest     = dest_q;
  assign wb_err      = err_q;

endmodule

// File: tb/tb_load_access_ctrl.sv
// Bench for load_access_ctrl: directed and random loads against a byte-level reference model.
// Driver pushes expectations when issuing; a negedge process models memory and pops/compares writebacks.
`timescale 1ns/1ps
module tb_load_access_ctrl;

  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LWL = 6'h22;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] LWR = 6'h26;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_opcode = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_rt_old = '0;
  logic [4:0]  req_dest = '0;
  logic        mem_read;
  logic [31:0] mem_address;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_readdata = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        wb_err;

  load_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_rt_old(req_rt_old), .req_dest(req_dest),
    .mem_read(mem_read), .mem_address(mem_address),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_dest(wb_dest), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rd;
    int          nw;
    int          nh;
    logic [31:0] data;
    logic [4:0]  dest;
    logic        err;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rd;
    int          nw;
    int          nh;
    logic [31:0] x;
    logic        xe;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   rd_cnt = 0;
  int   hold_cnt = 0;
  bit   held = 1'b0;
  logic [31:0] p_data;
  logic [4:0]  p_dest;
  logic        p_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Which opcode/address pairs are accepted loads
  function automatic bit legal(input logic [5:0] op, input logic [31:0] a);
    if (op inside {LB, LBU, LWL, LWR}) return 1'b1;
    if (op inside {LH, LHU}) return (a[0] == 1'b0);
    if (op == LW) return (a[1:0] == 2'b00);
    return 1'b0;
  endfunction

  // Reference: treat memory word and rt as four big-endian bytes and move bytes around
  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [1:0] k,
                                           input logic [31:0] rd, input logic [31:0] rt);
    logic [7:0] m [4];
    logic [7:0] r [4];
    int kk;
    kk = int'(k);
    for (int i = 0; i < 4; i++) begin
      m[i] = rd[31-8*i -: 8];
      r[i] = rt[31-8*i -: 8];
    end
    case (op)
      LW:  return rd;
      LB:  return {{24{m[kk][7]}}, m[kk]};
      LBU: return {24'h0, m[kk]};
      LH:  return {{16{m[kk][7]}}, m[kk], m[kk+1]};
      LHU: return {16'h0, m[kk], m[kk+1]};
      LWL: begin
        for (int i = kk; i < 4; i++) r[i-kk] = m[i];
        return {r[0], r[1], r[2], r[3]};
      end
      LWR: begin
        for (int i = 0; i <= kk; i++) r[3-kk+i] = m[i];
        return {r[0], r[1], r[2], r[3]};
      end
      default: return 32'h0;
    endcase
  endfunction

  // Push the expectation, wait for req_ready (spraying ignored requests while busy), then present the load
  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic [4:0] dest, input logic [31:0] rd, input int nw, input int nh,
                       input logic [31:0] xdata, input logic xerr);
    exp_t e;
    int guard;
    e.addr = {addr[31:2], 2'b00};
    e.rd = rd; e.nw = nw; e.nh = nh; e.data = xdata; e.dest = dest; e.err = xerr;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 400) begin
      req_valid  = 1'($urandom);
      req_opcode = 6'($urandom);
      req_addr   = $urandom;
      req_rt_old = $urandom;
      req_dest   = 5'($urandom);
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_ready_wait: got 0 expected 1 within 400 cycles (t=%0t)", $time);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    req_valid  = 1'b1;
    req_opcode = op;
    req_addr   = addr;
    req_rt_old = rt;
    req_dest   = dest;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    req_addr  = $urandom;
  endtask

  // Memory model and writeback monitor; stimulus-independent, driven by the scoreboard front
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_cnt = 0; hold_cnt = 0; held = 1'b0;
        mem_waitrequest = 1'b0; wb_ready = 1'b0;
      end else begin
        if (mem_read) begin
          rd_cnt++;
          chk("req_ready_in_read", 32'(req_ready), 32'd0);
          if (exp_q.size() == 0) begin
            chk("spurious_read", 32'(mem_read), 32'd0);
            mem_waitrequest = 1'b0;
          end else begin
            chk("mem_address", mem_address, exp_q[0].addr);
            mem_waitrequest = (rd_cnt <= exp_q[0].nw);
            mem_readdata    = exp_q[0].rd;
          end
        end else begin
          mem_waitrequest = 1'($urandom);
          mem_readdata    = $urandom;
        end

        if (wb_valid) begin
          if (held) begin
            chk("wb_data_stable", wb_data, p_data);
            chk("wb_dest_stable", 32'(wb_dest), 32'(p_dest));
            chk("wb_err_stable", 32'(wb_err), 32'(p_err));
          end else if (exp_q.size() != 0) begin
            chk("wb_latency", 32'(cyc - acc_cyc), exp_q[0].err ? 32'd0 : 32'(exp_q[0].nw + 1));
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_wb", 32'(wb_valid), 32'd0);
            wb_ready = 1'b1;
          end else if (hold_cnt < exp_q[0].nh) begin
            hold_cnt++;
            held = 1'b1;
            p_data = wb_data; p_dest = wb_dest; p_err = wb_err;
            wb_ready = 1'b0;
          end else begin
            chk("wb_data", wb_data, exp_q[0].data);
            chk("wb_dest", 32'(wb_dest), 32'(exp_q[0].dest));
            chk("wb_err", 32'(wb_err), 32'(exp_q[0].err));
            chk("read_cycles", 32'(rd_cnt), exp_q[0].err ? 32'd0 : 32'(exp_q[0].nw + 1));
            chk("req_ready_in_wb", 32'(req_ready), 32'd0);
            void'(exp_q.pop_front());
            rd_cnt = 0; hold_cnt = 0; held = 1'b0;
            wb_ready = 1'b1;
          end
        end else begin
          held = 1'b0;
          wb_ready = 1'($urandom);
        end
      end
    end
  end

  vec_t vt [10];

  initial begin
    logic [5:0]  op;
    logic [31:0] addr, rt, rd;
    bit          ok;
    int          idx, guard;

    vt[0] = '{LW,    32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 1'b0};
    vt[1] = '{LB,    32'h203, 32'h0,        32'h112233F0, 0, 0, 32'hFFFFFFF0, 1'b0};
    vt[2] = '{LBU,   32'h203, 32'h0,        32'h112233F0, 0, 0, 32'h000000F0, 1'b0};
    vt[3] = '{LWL,   32'h301, 32'h11223344, 32'hAABBCCDD, 0, 0, 32'hBBCCDD44, 1'b0};
    vt[4] = '{LWR,   32'h301, 32'h11223344, 32'hAABBCCDD, 0, 0, 32'h1122AABB, 1'b0};
    vt[5] = '{LHU,   32'h702, 32'h0,        32'h1234ABCD, 0, 0, 32'h0000ABCD, 1'b0};
    vt[6] = '{LH,    32'h700, 32'h0,        32'h8001FFFF, 1, 1, 32'hFFFF8001, 1'b0};
    vt[7] = '{LW,    32'h600, 32'h0,        32'h12345678, 3, 2, 32'h12345678, 1'b0};
    vt[8] = '{LH,    32'h401, 32'h0,        32'h55555555, 0, 0, 32'h0,        1'b1};
    vt[9] = '{6'h27, 32'h400, 32'h0,        32'h55555555, 0, 1, 32'h0,        1'b1};

    // Reset values while rst_n is held low
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_dest", 32'(wb_dest), 32'd0);
    chk("rst_wb_err", 32'(wb_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      issue(vt[i].op, vt[i].addr, vt[i].rt, 5'(i + 1), vt[i].rd, vt[i].nw, vt[i].nh, vt[i].x, vt[i].xe);

    // Reset in the middle of a stalled read: outputs drop at once and the transaction is gone
    issue(LW, 32'h500, 32'h0, 5'd7, 32'hCAFEF00D, 10000, 0, 32'hCAFEF00D, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_read", 32'(mem_read), 32'd0);
    chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("midrst_wb_err", 32'(wb_err), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_req_ready", 32'(req_ready), 32'd1);
    issue(LW, 32'h104, 32'h0, 5'd9, 32'h0BADC0DE, 0, 0, 32'h0BADC0DE, 1'b0);

    // Random loads checked against the byte-level model
    for (int t = 0; t < 300; t++) begin
      idx  = $urandom_range(0, 8);
      op   = (idx < 7) ? (LB + 6'(idx)) : 6'($urandom);
      addr = $urandom;
      rt   = $urandom;
      rd   = $urandom;
      if ((op == LH || op == LHU) && $urandom_range(0, 3) != 0) addr[0] = 1'b0;
      if (op == LW && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      ok = legal(op, addr);
      issue(op, addr, rt, 5'($urandom), rd, $urandom_range(0, 4), $urandom_range(0, 3),
            ok ? ref_load(op, addr[1:0], rd, rt) : 32'h0, !ok);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_outstanding", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_access_ctrl.md
Name: load_access_ctrl

Overview:
Sequencer between the pipeline's memory stage and the Harvard data memory for all load instructions (LB, LH, LWL, LW, LBU, LHU, LWR).
- Accepts one load request and issues a word-aligned read to data memory, holding it through memory wait states.
- Merges the returned word with the old rt value per opcode and byte offset (big-endian), then presents the result on a writeback handshake.
- One load is outstanding at a time; the pipeline stalls on req_ready low.

Parameters:
TIMEOUT_CYCLES, 255, maximum wait-state cycles before a read is abandoned (only used with the optional feature).
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  load request present
req_ready  output  1  controller can accept a request
req_opcode  input  6  instruction[31:26] of the load
req_addr  input  32  effective byte address
req_rt_old  input  32  current rt value, used for LWL/LWR merge
req_dest  input  5  destination register index
mem_read  output  1  data memory read strobe
mem_address  output  32  word-aligned read address, bits [1:0] always 0
mem_waitrequest  input  1  memory stall; read data is valid in the cycle mem_read=1 and waitrequest=0
mem_readdata  input  32  memory read data
wb_valid  output  1  writeback result valid
wb_ready  input  1  writeback consumer accepts the result
wb_data  output  32  merged load result
wb_dest  output  5  destination register index
wb_err  output  1  address/opcode error; wb_data=0 when set

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=0 while in reset; all other outputs 0; internal registers 0. Reset mid-read drops mem_read immediately and returns no data.
- States:
  - IDLE: req_ready=1. On req_valid, capture opcode, addr, rt_old and dest.
    - If the request is valid, go to READ.
    - If it is misaligned (LW with addr[1:0]≠0; LH/LHU with addr[0]≠0) or the opcode is not one of the seven loads: set wb_err=1, wb_data=0, and go to WB. No memory access is made.
  - READ: mem_read=1, mem_address={addr[31:2],2'b00}.
    - waitrequest=1: stay in READ; mem_address stays stable.
    - waitrequest=0: register the merged result into wb_data, wb_err=0, go to WB.
  - WB: wb_valid=1; wb_data, wb_dest and wb_err are stable until wb_ready=1. On wb_ready, go to IDLE.
  - req_ready=0 in READ and WB. No bypass: the earliest re-accept is the cycle after the WB handshake.
- Latency with zero wait states: accept at cycle N, mem_read high at N+1, wb_valid at N+2.
- Merge rules. k=addr[1:0]; byte offset 0 = readdata[31:24]; B(k)=readdata[31-8k -: 8].
  - LW: readdata.
  - LB: sign-extend B(k). LBU: zero-extend B(k).
  - LH: sign-extend readdata[31:16] (k=0) or readdata[15:0] (k=2). LHU: the same halves, zero-extended.
  - LWL by k:
    - k=0: readdata
    - k=1: {readdata[23:0], rt_old[7:0]}
    - k=2: {readdata[15:0], rt_old[15:0]}
    - k=3: {readdata[7:0], rt_old[23:0]}
  - LWR by k:
    - k=0: {rt_old[31:8], readdata[31:24]}
    - k=1: {rt_old[31:16], readdata[31:16]}
    - k=2: {rt_old[31:24], readdata[31:8]}
    - k=3: readdata
  - LWL/LWR never raise a misalignment error.
- Simultaneous wb_ready and new req_valid in WB: the request is not accepted that cycle.
- wb_ready while in IDLE or READ is ignored.

Optional Feature:
LOAD_ACCESS_CTRL_TIMEOUT_EN:
- Defined:
  - A CNT_W counter clears on entry to READ and increments each READ cycle with waitrequest=1.
  - When the count reaches TIMEOUT_CYCLES with waitrequest still 1, mem_read drops and the controller goes to WB with wb_err=1 and wb_data=0.
  - A response on the same cycle the count reaches TIMEOUT_CYCLES (waitrequest=0) wins: normal data, no error.
- Undefined: no counter; READ waits indefinitely.

Test Plan:
- LW addr=0x100, readdata=0xDEADBEEF, zero waits → mem_read at N+1 with mem_address=0x100; wb_valid at N+2, wb_data=0xDEADBEEF, wb_err=0.
- LB addr=0x203 and LBU addr=0x203, readdata=0x112233F0 → LB gives 0xFFFFFFF0, LBU gives 0x000000F0; mem_address=0x200.
- LWL/LWR addr=0x301, readdata=0xAABBCCDD, rt_old=0x11223344 → LWL gives 0xBBCCDD44, LWR gives 0x1122AABB.
- LH addr=0x401 → no mem_read; wb_valid with wb_err=1, wb_data=0. Opcode 6'b100111 gives the same result.
- Three waitrequest cycles, then wb_ready held low 2 cycles → mem_read high for 4 cycles with mem_address stable; wb_data stable until wb_ready; req_ready low throughout.
- rst_n pulsed low mid-READ → mem_read, wb_valid and wb_err are 0 immediately; after release req_ready=1 and a following LW completes normally. With LOAD_ACCESS_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=4, waitrequest held high → wb_err=1 after 4 wait cycles.
